mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Serializes instruction-fetch and data requests from the pipelined datapath onto one single-ported RAM interface.
- Produces the ihit/dhit pulses consumed by the hazard unit to enable pipeline registers and PC.
- Sits between the datapath request signals and the RAM model.
- Data requests take priority over fetches; a watchdog bounds every RAM access.

Parameters:
- TIMEOUT, 64: maximum consecutive access cycles with ram_ready low before the access is aborted.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an aborted read.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous reset, active low.
- iREN  in  1  instruction fetch request.
- iaddr  in  32  fetch address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- ihit  out  1  one-cycle fetch-complete pulse.
- dhit  out  1  one-cycle data-complete pulse.
- iload  out  32  fetched instruction, valid while ihit=1.
- dload  out  32  read data, valid while dhit=1 for a read.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  32  RAM address.
- ram_store  out  32  RAM write data.
- ram_load  in  32  RAM read data.
- ram_ready  in  1  RAM access complete this cycle.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- One clock domain: CLK. Reset nRST is asynchronous, active low.
- Reset forces, immediately and independent of CLK:
  - state=IDLE;
  - ihit, dhit, ram_ren, ram_wen, timeout_err = 0;
  - iload, dload, ram_addr, ram_store = 0;
  - wait counter=0.
- Reset mid-access drops ram_ren/ram_wen at once; the access is abandoned and no hit is issued.
- All outputs are registered.
- FSM states: IDLE, DACC, IACC, HIT.
- IDLE transitions:
  - dREN|dWEN → DACC. Latch daddr, dstore, and kind. Kind is write if dWEN=1; dWEN overrides dREN, and ram_ren=0 for that access.
  - else iREN → IACC. Latch iaddr.
  - Same-cycle data and fetch requests: data wins; the fetch is served after HIT if iREN is still high.
- DACC/IACC:
  - Drive ram_addr and the strobe (ram_ren for reads, ram_wen for writes, ram_store for writes) from the latched values.
  - Request inputs are ignored; changes or withdrawal of requests do not affect the access in flight.
- Completion: ram_ready=1 sampled in an access state → next cycle HIT, with these outputs for exactly one cycle:
  - DACC: dhit=1, dload=ram_load for a read; for a write, dload holds its previous value.
  - IACC: ihit=1, iload=ram_load.
  - Strobes deassert in HIT.
- HIT → IDLE unconditionally.
  - Requests are not sampled in HIT; the requester still asserts them during the hit cycle, and sampling would re-issue the access.
  - ihit and dhit are never both 1.
- Latency: request seen in IDLE at cycle 0 → strobe high in cycle 1 → ram_ready at cycle k≥1 → hit at cycle k+1.
  - Minimum 2 cycles request-to-hit.
  - Back-to-back accesses: one access per 3 cycles minimum (IDLE, ACC, HIT).
- Watchdog:
  - Counter width is $clog2(TIMEOUT+1).
  - It clears on entry to an access state and increments each access cycle with ram_ready=0.
  - If the counter reaches TIMEOUT-1 while ram_ready=0, the next state is HIT. The hit pulses as normal, the load output is ERR_WORD (reads only), and timeout_err is set to 1.
  - ram_ready=1 in the same cycle as expiry counts as normal completion; no error.
  - timeout_err stays 1 until reset.
- Address and data pass through unmodified: no alignment checks, no byte lanes.

Test Plan:
- Reset: hold nRST=0 mid-DACC with ram_ren=1 → ram_ren drops without waiting for CLK; after release, all outputs are 0 and the state is IDLE; no dhit ever appears.
- Fetch: iREN=1, iaddr=0x40, RAM ready 1 cycle after strobe with ram_load=0x8C220004 → ram_ren=1 and ram_addr=0x40 in cycle 1; ihit=1 and iload=0x8C220004 in cycle 2 only.
- Priority: iREN=1 and dREN=1 (daddr=0x100) in the same cycle, RAM ready immediately → the data access is served first and dhit pulses; then ram_addr=iaddr follows and ihit pulses; at no point are ihit and dhit both 1.
- Write: dREN=1 and dWEN=1 together, daddr=0x200, dstore=0xDEADBEEF → ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF; dhit pulses; dload is unchanged.
- Held request: requester keeps dREN=1 through the HIT cycle, then drops it → exactly one RAM access and one dhit.
- Watchdog: TIMEOUT=4, ram_ready held 0 → hit on the cycle after the 4th access cycle with dload=0xBAD1BAD1 and timeout_err=1, sticky. Rerun with ram_ready=1 on the 4th cycle → normal completion, timeout_err stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the datapath, the arbiter and the single-ported RAM.
interface mem_arbiter_if;
    localparam int unsigned WORD_W = 32;

    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [WORD_W-1:0] iload;
    logic [WORD_W-1:0] dload;
    logic              ram_ren;
    logic              ram_wen;
    logic [WORD_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_store;
    logic [WORD_W-1:0] ram_load;
    logic              ram_ready;
    logic              timeout_err;

    // Arbiter view
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
        output ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, timeout_err
    );

    // Datapath + RAM model view
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
        input  ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes fetch and data requests onto one RAM port; data has priority,
// and a watchdog aborts any access whose ram_ready never arrives.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DACC, IACC, HIT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic               ihit_q, ihit_d;
    logic               dhit_q, dhit_d;
    logic               ram_ren_q, ram_ren_d;
    logic               ram_wen_q, ram_wen_d;
    logic               timeout_err_q, timeout_err_d;
    logic [WORD_W-1:0]  iload_q, iload_d;
    logic [WORD_W-1:0]  dload_q, dload_d;
    logic [WORD_W-1:0]  ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0]  ram_store_q, ram_store_d;
    logic               expire;
    logic [WORD_W-1:0]  rd_word;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_wr_q       <= 1'b0;
            ihit_q        <= 1'b0;
            dhit_q        <= 1'b0;
            ram_ren_q     <= 1'b0;
            ram_wen_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            iload_q       <= '0;
            dload_q       <= '0;
            ram_addr_q    <= '0;
            ram_store_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_wr_q       <= is_wr_d;
            ihit_q        <= ihit_d;
            dhit_q        <= dhit_d;
            ram_ren_q     <= ram_ren_d;
            ram_wen_q     <= ram_wen_d;
            timeout_err_q <= timeout_err_d;
            iload_q       <= iload_d;
            dload_q       <= dload_d;
            ram_addr_q    <= ram_addr_d;
            ram_store_q   <= ram_store_d;
        end
    end

    // An expired access still completes through HIT, returning ERR_WORD for reads.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_wr_d       = is_wr_q;
        ihit_d        = 1'b0;
        dhit_d        = 1'b0;
        ram_ren_d     = ram_ren_q;
        ram_wen_d     = ram_wen_q;
        timeout_err_d = timeout_err_q;
        iload_d       = iload_q;
        dload_d       = dload_q;
        ram_addr_d    = ram_addr_q;
        ram_store_d   = ram_store_q;
        expire        = !bus.ram_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
        rd_word       = bus.ram_ready ? bus.ram_load : ERR_WORD;

        unique case (state_q)
            IDLE: begin
                if (bus.dREN || bus.dWEN) begin
                    state_d    = DACC;
                    cnt_d      = '0;
                    is_wr_d    = bus.dWEN;
                    ram_ren_d  = !bus.dWEN;
                    ram_wen_d  = bus.dWEN;
                    ram_addr_d = bus.daddr;
                    if (bus.dWEN) begin
                        ram_store_d = bus.dstore;
                    end
                end else if (bus.iREN) begin
                    state_d    = IACC;
                    cnt_d      = '0;
                    is_wr_d    = 1'b0;
                    ram_ren_d  = 1'b1;
                    ram_wen_d  = 1'b0;
                    ram_addr_d = bus.iaddr;
                end
            end
            DACC, IACC: begin
                if (bus.ram_ready || expire) begin
                    state_d   = HIT;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    if (expire) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == DACC) begin
                        dhit_d = 1'b1;
                        if (!is_wr_q) begin
                            dload_d = rd_word;
                        end
                    end else begin
                        ihit_d  = 1'b1;
                        iload_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Requests are still held during the hit cycle; ignore them here.
            HIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ihit        = ihit_q;
    assign bus.dhit        = dhit_q;
    assign bus.iload       = iload_q;
    assign bus.dload       = dload_q;
    assign bus.ram_ren     = ram_ren_q;
    assign bus.ram_wen     = ram_wen_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_store   = ram_store_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests against a small RAM model,
// expected hits queued at drive time and compared when ihit/dhit appear.
module tb_mem_arbiter;
    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hBAD1BAD1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TO), .ERR_WORD(ERR)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          is_fetch;
        logic [31:0] load;
        bit          terr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_dload = '0;
    bit          model_terr  = 1'b0;
    int          extra_hits  = 0;
    int          ram_accesses = 0;
    logic [31:0] mem [logic [31:0]];
    int          ram_lat  = 0;
    bit          ram_hang = 1'b0;
    int          acc_cyc  = 0;

    function automatic logic [31:0] ram_word(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (a == 32'h40) return 32'h8C220004;
        return a ^ 32'h13579BDF;
    endfunction

    // RAM model: answers ram_lat strobe cycles after the strobe rises unless hung
    always @(negedge CLK) begin
        if (bus.ram_ren || bus.ram_wen) begin
            if (acc_cyc == 0) ram_accesses++;
            if (!ram_hang && acc_cyc >= ram_lat) begin
                bus.ram_ready = 1'b1;
                bus.ram_load  = bus.ram_ren ? ram_word(bus.ram_addr) : 32'h0;
                if (bus.ram_wen) mem[bus.ram_addr] = bus.ram_store;
            end else begin
                bus.ram_ready = 1'b0;
            end
            acc_cyc++;
        end else begin
            acc_cyc       = 0;
            bus.ram_ready = 1'b0;
        end
    end

    // Hit monitor
    always @(negedge CLK) begin
        if (nRST && (bus.ihit || bus.dhit)) begin
            check("hit_exclusive", 32'(bus.ihit & bus.dhit), 32'h0);
            if (sb.size() == 0) begin
                extra_hits++;
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hit_kind", 32'(bus.ihit), 32'(e.is_fetch));
                check(e.is_fetch ? "iload" : "dload", e.is_fetch ? bus.iload : bus.dload, e.load);
                check("terr_at_hit", 32'(bus.timeout_err), 32'(e.terr));
            end
        end
    end

    task automatic push_fetch(logic [31:0] a);
        sb.push_back('{1'b1, ram_word(a), model_terr});
    endtask

    task automatic push_dread(logic [31:0] a, bit timed_out);
        if (timed_out) begin
            model_terr  = 1'b1;
            model_dload = ERR;
        end else begin
            model_dload = ram_word(a);
        end
        sb.push_back('{1'b0, model_dload, model_terr});
    endtask

    task automatic push_dwrite();
        sb.push_back('{1'b0, model_dload, model_terr});
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_hit();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.ihit || bus.dhit) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check("hit_seen", 32'(ok), 32'h1);
    endtask

    task automatic idle_inputs();
        bus.iREN   = 1'b0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.iaddr  = '0;
        bus.daddr  = '0;
        bus.dstore = '0;
    endtask

    task automatic check_zero(string pfx);
        check({pfx, "_ihit"},  32'(bus.ihit), 32'h0);
        check({pfx, "_dhit"},  32'(bus.dhit), 32'h0);
        check({pfx, "_ren"},   32'(bus.ram_ren), 32'h0);
        check({pfx, "_wen"},   32'(bus.ram_wen), 32'h0);
        check({pfx, "_terr"},  32'(bus.timeout_err), 32'h0);
        check({pfx, "_iload"}, bus.iload, 32'h0);
        check({pfx, "_dload"}, bus.dload, 32'h0);
        check({pfx, "_addr"},  bus.ram_addr, 32'h0);
        check({pfx, "_store"}, bus.ram_store, 32'h0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        model_dload = '0;
        model_terr  = 1'b0;
        cyc();
        cyc();
        nRST = 1'b1;
    endtask

    initial begin
        idle_inputs();
        bus.ram_ready = 1'b0;
        bus.ram_load  = '0;
        do_reset();
        check_zero("rst");
        cyc();

        // Fetch with single-cycle RAM
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        push_fetch(32'h40);
        cyc();
        check("f_ren", 32'(bus.ram_ren), 32'h1);
        check("f_addr", bus.ram_addr, 32'h40);
        check("f_ihit_c1", 32'(bus.ihit), 32'h0);
        cyc();
        check("f_ihit_c2", 32'(bus.ihit), 32'h1);
        check("f_iload", bus.iload, 32'h8C220004);
        bus.iREN = 1'b0;
        cyc();
        check("f_ihit_c3", 32'(bus.ihit), 32'h0);

        // Simultaneous data and fetch: data first
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h44;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h100;
        push_dread(32'h100, 1'b0);
        push_fetch(32'h44);
        cyc();
        check("p_daddr", bus.ram_addr, 32'h100);
        check("p_dren", 32'(bus.ram_ren), 32'h1);
        cyc();
        check("p_dhit", 32'(bus.dhit), 32'h1);
        bus.dREN = 1'b0;
        cyc();
        cyc();
        check("p_iaddr", bus.ram_addr, 32'h44);
        check("p_iren", 32'(bus.ram_ren), 32'h1);
        cyc();
        check("p_ihit", 32'(bus.ihit), 32'h1);
        bus.iREN = 1'b0;
        cyc();
        cyc();

        // Write: dWEN overrides dREN, dload untouched
        bus.dREN   = 1'b1;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h200;
        bus.dstore = 32'hDEADBEEF;
        push_dwrite();
        cyc();
        check("w_wen", 32'(bus.ram_wen), 32'h1);
        check("w_ren", 32'(bus.ram_ren), 32'h0);
        check("w_store", bus.ram_store, 32'hDEADBEEF);
        check("w_addr", bus.ram_addr, 32'h200);
        cyc();
        check("w_dhit", 32'(bus.dhit), 32'h1);
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        cyc();
        cyc();
        check("w_mem", ram_word(32'h200), 32'hDEADBEEF);
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
        push_dread(32'h200, 1'b0);
        cyc();
        wait_hit();
        bus.dREN = 1'b0;
        cyc();
        cyc();

        // Request held through the hit cycle
        begin
            int acc0;
            ram_lat   = 2;
            acc0      = ram_accesses;
            bus.dREN  = 1'b1;
            bus.daddr = 32'h300;
            push_dread(32'h300, 1'b0);
            cyc();
            wait_hit();
            cyc();
            bus.dREN = 1'b0;
            repeat (5) cyc();
            check("held_accesses", 32'(ram_accesses - acc0), 32'h1);
            ram_lat = 0;
        end

        // Watchdog expiry
        ram_hang  = 1'b1;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h400;
        push_dread(32'h400, 1'b1);
        cyc();
        check("wd_ren", 32'(bus.ram_ren), 32'h1);
        repeat (3) begin
            cyc();
            check("wd_no_hit", 32'(bus.dhit), 32'h0);
        end
        cyc();
        check("wd_dhit", 32'(bus.dhit), 32'h1);
        check("wd_dload", bus.dload, ERR);
        check("wd_terr", 32'(bus.timeout_err), 32'h1);
        bus.dREN = 1'b0;
        ram_hang = 1'b0;
        cyc();
        cyc();
        check("wd_sticky", 32'(bus.timeout_err), 32'h1);
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h48;
        push_fetch(32'h48);
        cyc();
        wait_hit();
        bus.iREN = 1'b0;
        cyc();
        cyc();
        check("wd_sticky2", 32'(bus.timeout_err), 32'h1);

        // Ready on the last allowed cycle is a normal completion
        do_reset();
        check("wd2_terr_rst", 32'(bus.timeout_err), 32'h0);
        ram_lat   = 3;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h404;
        push_dread(32'h404, 1'b0);
        cyc();
        repeat (3) begin
            cyc();
            check("wd2_no_hit", 32'(bus.dhit), 32'h0);
        end
        cyc();
        check("wd2_dhit", 32'(bus.dhit), 32'h1);
        check("wd2_dload", bus.dload, 32'h404 ^ 32'h13579BDF);
        check("wd2_terr", 32'(bus.timeout_err), 32'h0);
        bus.dREN = 1'b0;
        ram_lat  = 0;
        cyc();
        cyc();
        check("wd2_terr_after", 32'(bus.timeout_err), 32'h0);

        // Reset in the middle of a data access
        ram_hang  = 1'b1;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h500;
        cyc();
        check("ra_ren_before", 32'(bus.ram_ren), 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        check("ra_ren_async", 32'(bus.ram_ren), 32'h0);
        check("ra_addr_async", bus.ram_addr, 32'h0);
        idle_inputs();
        model_dload = '0;
        model_terr  = 1'b0;
        cyc();
        cyc();
        nRST = 1'b1;
        check_zero("ra");
        ram_hang = 1'b0;
        repeat (5) cyc();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        push_fetch(32'h40);
        cyc();
        check("ra_f_ren", 32'(bus.ram_ren), 32'h1);
        check("ra_f_addr", bus.ram_addr, 32'h40);
        cyc();
        check("ra_f_ihit", 32'(bus.ihit), 32'h1);
        bus.iREN = 1'b0;
        repeat (4) cyc();

        check("sb_drained", 32'(sb.size()), 32'h0);
        check("extra_hits", 32'(extra_hits), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
